dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Initiator-side load/store controller that drives the data memory's word-addressed port (address, mem_write, mem_read, write_data, read_data) on behalf of the CPU pipeline.
- Accepts byte-addressed word and byte load/store requests through a valid/ready handshake, converts byte addresses to word indices, and extracts and extends byte-load results.
- Performs read-modify-write for byte stores, because the memory only writes whole words.
- Returns one response per request, or an error response for misaligned or out-of-range accesses.

Parameters:
- size, 32, data and address width in bits (matches the memory's size).
- MemSize, 32, highest legal word index; the memory holds words 0..MemSize.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  size  byte address.
- req_wdata  in  size  store data; byte stores use bits [7:0].
- resp_valid  out  1  one-cycle response strobe.
- resp_error  out  1  qualifies resp_valid; request was rejected.
- resp_rdata  out  size  load result, valid with resp_valid; 0 for stores and errors.
- mem_address  out  size  word index to the memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe; the memory writes on the clk edge ending a cycle where this is 1.
- mem_write_data  out  size  word written.
- mem_read_data  in  size  combinational read data for mem_address.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE; req_ready=0 while rst=1; resp_valid=0, resp_error=0, resp_rdata=0; mem_address=0, mem_read=0, mem_write=0, mem_write_data=0.
- Gating: mem_read and mem_write are additionally gated by !rst, so no memory write ever occurs in a cycle where rst=1.
- States: IDLE, READ, WRITE, RESP, ERR.
- req_ready = (state==IDLE) && !rst. A request is accepted on the edge where req_valid && req_ready. On acceptance, all request fields are registered; inputs are ignored outside IDLE.
- Address conversion: word index = req_addr >> 2; lane = req_addr[1:0].
- Error check at accept, in priority order:
  - word access with lane != 0 (misaligned);
  - word index > MemSize.
  - Either condition -> ERR, with no memory strobe at all.
- Transitions after accept (non-error):
  - load (word or byte) -> READ;
  - byte store -> READ;
  - word store -> WRITE.
- READ (1 cycle):
  - mem_read=1, mem_address=index.
  - At the end of the cycle, mem_read_data is captured.
  - Load -> RESP. Byte store: build the merged word (captured word with lane byte replaced by req_wdata[7:0]) -> WRITE.
- WRITE (1 cycle):
  - mem_write=1, mem_address=index, mem_write_data = req_wdata (word store) or the merged word (byte store).
  - -> RESP.
- RESP (1 cycle): resp_valid=1, resp_error=0.
  - Word load: resp_rdata = captured word.
  - Byte load: resp_rdata = byte at lane (lane 0 = bits [7:0], little-endian), sign- or zero-extended to size.
  - -> IDLE.
- ERR (1 cycle): resp_valid=1, resp_error=1, resp_rdata=0 -> IDLE.
- Latency, counted from the accept edge to the resp_valid cycle:
  - word/byte load: 2 cycles;
  - word store: 2 cycles;
  - byte store: 3 cycles;
  - error: 1 cycle.
- Throughput: the next request can be accepted in the cycle after resp_valid (req_ready returns to 1 in IDLE).
- Strobe rules: mem_read and mem_write are never high in the same cycle, and are 0 in IDLE, RESP and ERR.
- Reset mid-operation: any state returns to IDLE on the next edge. The in-flight request is dropped with no response. A byte store reset during READ issues no write.
- Boundaries:
  - Index = MemSize is legal; MemSize+1 is an error.
  - A byte access with any lane is legal.
  - req_addr upper bits beyond the index range trigger the out-of-range error; there is no wrap-around.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x14 (index 5). Expect mem_write high exactly one cycle with mem_address=5 and resp after 2 cycles. Load 0x14 returns resp_rdata=0xDEADBEEF 2 cycles after accept.
- Byte store RMW: with word 5 = 0xDEADBEEF, store byte 0x55 to addr 0x16. Expect a READ cycle, then a WRITE of 0xDE55BEEF, resp 3 cycles after accept. A word load of 0x14 then returns 0xDE55BEEF.
- Byte load extension: with word 5 = 0xDE55BEEF, load addr 0x17 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load addr 0x14 signed -> 0xFFFFFFEF.
- Errors: word load at 0x15 -> resp_error=1 one cycle after accept, no mem_read. Word store to index 33 (addr 0x84) with MemSize=32 -> resp_error=1, no mem_write. Index 32 (addr 0x80) succeeds.
- Handshake: hold req_valid high with back-to-back requests. req_ready is 0 from the accept edge until the cycle after resp_valid; each request gets exactly one response, in order.
- Reset mid-op: assert rst during READ of a byte store to index 2 (prior value 0x12345678). Expect no mem_write, no resp_valid, and IDLE with req_ready=1 after rst is released. Word 2 still reads 0x12345678.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store controller between the CPU pipeline and a word-addressed data memory.
// Converts byte addresses to word indices, merges byte stores, and extends byte loads.
module dmem_access_ctrl #(
  parameter int unsigned size    = 32,
  parameter int unsigned MemSize = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_write,
  input  logic            i_req_byte,
  input  logic            i_req_signed,
  input  logic [size-1:0] i_req_addr,
  input  logic [size-1:0] i_req_wdata,
  output logic            o_resp_valid,
  output logic            o_resp_error,
  output logic [size-1:0] o_resp_rdata,
  output logic [size-1:0] o_mem_address,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [size-1:0] o_mem_write_data,
  input  logic [size-1:0] i_mem_read_data
);

  localparam int unsigned LaneW = 2;
  localparam int unsigned ExtW  = size - 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;

  logic             r_write;
  logic             r_byte;
  logic             r_signed;
  logic [LaneW-1:0] r_lane;
  logic [size-1:0]  r_index;
  logic [size-1:0]  r_wdata;
  logic [size-1:0]  r_rdata;

  logic             w_accept;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic             w_error;
  logic [size-1:0]  w_index;
  logic [size-1:0]  w_merged;
  logic [7:0]       w_lane_byte;
  logic [size-1:0]  w_load_data;

  assign w_accept       = i_req_valid && (r_state == S_IDLE) && !rst;
  assign w_index        = i_req_addr >> 2;
  assign w_misaligned   = !i_req_byte && (i_req_addr[LaneW-1:0] != 2'b00);
  assign w_out_of_range = w_index > size'(MemSize);
  assign w_error        = w_misaligned || w_out_of_range;

  // Byte store merge: replace the addressed lane of the word read back from memory
  always_comb begin
    w_merged = i_mem_read_data;
    case (r_lane)
      2'd0:    w_merged[7:0]   = r_wdata[7:0];
      2'd1:    w_merged[15:8]  = r_wdata[7:0];
      2'd2:    w_merged[23:16] = r_wdata[7:0];
      default: w_merged[31:24] = r_wdata[7:0];
    endcase
  end

  // Byte load extraction, little-endian lane order
  always_comb begin
    case (r_lane)
      2'd0:    w_lane_byte = r_rdata[7:0];
      2'd1:    w_lane_byte = r_rdata[15:8];
      2'd2:    w_lane_byte = r_rdata[23:16];
      default: w_lane_byte = r_rdata[31:24];
    endcase
    if (r_byte) begin
      w_load_data = {{ExtW{r_signed & w_lane_byte[7]}}, w_lane_byte};
    end else begin
      w_load_data = r_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs; every output is forced low while in reset
  always_comb begin
    w_state_nxt      = r_state;
    o_req_ready      = 1'b0;
    o_resp_valid     = 1'b0;
    o_resp_error     = 1'b0;
    o_resp_rdata     = '0;
    o_mem_address    = '0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_write_data = '0;

    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) begin
          if (w_error) begin
            w_state_nxt = S_ERR;
          end else if (i_req_write && !i_req_byte) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        o_mem_read    = 1'b1;
        o_mem_address = r_index;
        w_state_nxt   = r_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        o_mem_write      = 1'b1;
        o_mem_address    = r_index;
        o_mem_write_data = r_wdata;
        w_state_nxt      = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = r_write ? '0 : w_load_data;
        w_state_nxt  = S_IDLE;
      end
      S_ERR: begin
        o_resp_valid = 1'b1;
        o_resp_error = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (rst) begin
      o_req_ready      = 1'b0;
      o_resp_valid     = 1'b0;
      o_resp_error     = 1'b0;
      o_resp_rdata     = '0;
      o_mem_address    = '0;
      o_mem_read       = 1'b0;
      o_mem_write      = 1'b0;
      o_mem_write_data = '0;
    end
  end

  // Request capture at accept; read data capture (and byte-store merge) at the end of READ
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_lane   <= '0;
      r_index  <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_write  <= i_req_write;
        r_byte   <= i_req_byte;
        r_signed <= i_req_signed;
        r_lane   <= i_req_addr[LaneW-1:0];
        r_index  <= w_index;
        r_wdata  <= i_req_wdata;
      end
      if (r_state == S_READ) begin
        r_rdata <= i_mem_read_data;
        if (r_write) begin
          r_wdata <= w_merged;
        end
      end
    end
  end

endmodule
